// File: rtl/ref_bank_wr_ctrl_if.sv
// ============================================================================
// Module      : ref_bank_wr_ctrl_if
// Description : Upstream word handshake and bank-side write bus for
//               ref_bank_wr_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ref_bank_wr_ctrl_if #(
    parameter int NUM_BANK = 4,
    parameter int DW       = 64
);
    logic                in_valid;
    logic [DW-1:0]       in_data;
    logic                in_ready;
    logic [DW-1:0]       ref_out;
    logic                beg_en;
    logic [NUM_BANK-1:0] bank_sel;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ref_out,
        input  beg_en,
        input  bank_sel
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ref_out,
        output beg_en,
        output bank_sel
    );
endinterface

`default_nettype wire

// File: rtl/ref_bank_wr_ctrl.sv
// ============================================================================
// Module      : ref_bank_wr_ctrl
// Description : Round-robin feeder that spreads a reference-word stream over
//               NUM_BANK banks in SEG_LEN-word segments. Optional stall
//               counter enabled by macro REF_WR_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ref_bank_wr_ctrl #(
    parameter int NUM_BANK     = 4,
    parameter int SEG_LEN      = 24,
    parameter int SEG_PER_BANK = 4,
    parameter int DW           = 64,
    localparam int BANK_W      = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
    localparam int SEG_W       = (SEG_PER_BANK > 1) ? $clog2(SEG_PER_BANK) : 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    ref_bank_wr_ctrl_if.slave      bus,
    output logic [BANK_W-1:0]      bank_idx,
    output logic [SEG_W-1:0]       seg_idx,
    output logic                   busy,
    output logic                   done
`ifdef REF_WR_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int WC_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;

    localparam logic [WC_W-1:0]   c_word_last = WC_W'(SEG_LEN - 1);
    localparam logic [BANK_W-1:0] c_bank_last = BANK_W'(NUM_BANK - 1);
    localparam logic [SEG_W-1:0]  c_seg_last  = SEG_W'(SEG_PER_BANK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WC_W-1:0]     r_word_cnt;
    logic [BANK_W-1:0]   r_bank_idx;
    logic [SEG_W-1:0]    r_seg_idx;
    logic [DW-1:0]       r_ref_out;
    logic                r_beg_en;
    logic [NUM_BANK-1:0] r_bank_sel;
    logic                r_done;
    logic                w_in_ready;
    logic                w_busy;
    logic                w_accept;
    logic                w_seg_end;
    logic                w_bank_wrap;
    logic                w_last;

    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_seg_end   = (r_word_cnt == c_word_last);
    assign w_bank_wrap = w_seg_end & (r_bank_idx == c_bank_last);
    assign w_last      = w_bank_wrap & (r_seg_idx == c_seg_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (bus.in_valid && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters only move on an accept, so they are already zero on every
    // return to IDLE and need no explicit clear on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
            r_bank_idx <= '0;
            r_seg_idx  <= '0;
        end else if (w_accept) begin
            if (w_seg_end) begin
                r_word_cnt <= '0;
                if (w_bank_wrap) begin
                    r_bank_idx <= '0;
                    r_seg_idx  <= (r_seg_idx == c_seg_last) ? '0 : r_seg_idx + 1'b1;
                end else begin
                    r_bank_idx <= r_bank_idx + 1'b1;
                end
            end else begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    // ref_out holds through stalls; only the strobes drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_out  <= '0;
            r_beg_en   <= 1'b0;
            r_bank_sel <= '0;
            r_done     <= 1'b0;
        end else begin
            r_beg_en   <= w_accept;
            r_done     <= w_accept & w_last;
            r_bank_sel <= w_accept ? (NUM_BANK'(1) << r_bank_idx) : '0;
            if (w_accept) begin
                r_ref_out <= bus.in_data;
            end
        end
    end

`ifdef REF_WR_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_LOAD && !bus.in_valid && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bus.in_ready = w_in_ready;
    assign bus.ref_out  = r_ref_out;
    assign bus.beg_en   = r_beg_en;
    assign bus.bank_sel = r_bank_sel;
    assign bank_idx     = r_bank_idx;
    assign seg_idx      = r_seg_idx;
    assign busy         = w_busy;
    assign done         = r_done;

endmodule

`default_nettype wire

// File: doc/ref_bank_wr_ctrl.md
Name: ref_bank_wr_ctrl

Overview:
- Upstream feeder for the reference-pixel bank array.
- Accepts a stream of 64-bit reference words (8 pixels × 8 bit) over a valid/ready handshake.
- Distributes the words round-robin across NUM_BANK banks in segments of SEG_LEN words, driving each bank's write-enable and select strobes.
- A full load is NUM_BANK × SEG_PER_BANK × SEG_LEN words (default 4×4×24 = 384), which fills every 96-deep bank exactly once.

Parameters:
- NUM_BANK, 4, number of banks fed; bank_sel width.
- SEG_LEN, 24, consecutive words written to one bank before switching to the next.
- SEG_PER_BANK, 4, segments per bank per load (SEG_LEN × SEG_PER_BANK = bank depth 96).
- DW, 64, data word width (8 pixels).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins one load; honoured only in IDLE.
- in_valid  in  1  upstream word valid.
- in_data  in  DW  upstream reference word.
- in_ready  out  1  block can accept a word; combinational = (state==LOAD).
- ref_out  out  DW  registered word to the banks' data inputs.
- beg_en  out  1  registered write strobe, aligned with ref_out.
- bank_sel  out  NUM_BANK  registered one-hot bank select, aligned with ref_out; all-zero when beg_en=0.
- bank_idx  out  clog2(NUM_BANK)  bank currently being filled.
- seg_idx  out  clog2(SEG_PER_BANK)  current segment round.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle pulse when the last word has been issued.

Behaviour:
- Reset values: ref_out=0, beg_en=0, bank_sel=0, word_cnt=0, bank_idx=0, seg_idx=0, done=0, state=IDLE.
- Reset mid-load abandons the load with no further strobes. Banks' internal write pointers are reset by the same rst_n, so they stay aligned.
- States:
  - IDLE: start=1 → LOAD. All counters are already zero.
  - LOAD: each accept (in_valid & in_ready) advances the counters. The accept of the final word → DONE.
  - DONE: done=1 for exactly one cycle; in_ready=0; next cycle → IDLE.
- Accept cycle, effective next edge:
  - ref_out←in_data; beg_en←1; bank_sel←(1<<bank_idx).
  - Latency: 1 clk from accept to strobe.
- Non-accept cycle in LOAD: beg_en←0 and bank_sel←0. ref_out holds its last value, so bank write pointers do not advance while upstream stalls.
- Counter rules:
  - word_cnt counts 0..SEG_LEN-1.
  - When word_cnt reaches SEG_LEN-1 on an accept: word_cnt←0 and bank_idx increments.
  - When bank_idx wraps from NUM_BANK-1 to 0: seg_idx increments.
  - Final word: word_cnt=SEG_LEN-1, bank_idx=NUM_BANK-1, seg_idx=SEG_PER_BANK-1. All counters clear to 0; state←DONE.
- The beg_en/bank_sel for the final word are asserted in the same cycle as done.
- start while busy: ignored; no restart and no counter disturbance.
- start coincident with the DONE cycle: ignored. A new start is required once in IDLE.
- in_valid in IDLE or DONE: not accepted (in_ready=0); data must be held by upstream.
- Every bank receives exactly SEG_LEN×SEG_PER_BANK strobes per load. Per-bank strobes arrive in bursts of SEG_LEN, interleaved with other banks' bursts.

Optional Feature:
- Macro: REF_WR_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt[15:0]: counts LOAD cycles with in_valid=0, saturating at 16'hFFFF.
  - Cleared to 0 on reset and on the IDLE→LOAD transition; held in IDLE and DONE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start, then in_valid held high with in_data = word index 0..383 → each of the first 24 strobes has bank_sel=4'b0001 and ref_out = 0..23. Strobes 24..47 have 4'b0010. Strobe 96 is back to 4'b0001 with seg_idx=1. done pulses with the strobe for word 383. Exactly 96 strobes per bank.
- in_valid toggled 1,0,1,0 throughout a load → beg_en=0 and bank_sel=0 on every bubble cycle. Total strobes=384. With REF_WR_STALL_CNT_EN, stall_cnt equals the number of bubble cycles in LOAD.
- start pulsed at word 50 mid-load → no effect: word 50 still goes to bank 2, and done arrives after the 384th accept.
- rst_n asserted asynchronously at word 200, then released and start issued again → all outputs 0 immediately. The new load starts at bank_idx=0, seg_idx=0, word_cnt=0, and completes in 384 accepts.
- in_valid=1 while IDLE with no start for 10 cycles → in_ready=0, beg_en=0, no strobes.
- Second load started on the cycle after done has returned the block to IDLE → same sequence as the first load. bank_sel starts at 4'b0001 and ref_out latency is 1 clk.
